// File: rtl/fpdiv_ctrl_if.sv
// Control bundle between the fpdiv sequencer and its requester/datapath:
// start/abort handshake in, busy/done status plus datapath selects/enables out.
interface fpdiv_ctrl_if #(
  parameter int CW = 4
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [1:0]    sel_mux4;
  logic [1:0]    sel_mux3;
  logic          en_a;
  logic          en_b;
  logic          en_rem;
  logic          en_q;
  logic [CW-1:0] iter;

  modport master (
    output start, abort,
    input  busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, en_q, iter
  );

  modport slave (
    input  start, abort,
    output busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, en_q, iter
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for the Goldschmidt fpdiv datapath: seed multiply, ITERS
// A/B refinement passes, remainder capture. Optional RES stage: FPDIV_CTRL_RESULT_REG_EN.
module fpdiv_ctrl #(
  parameter int ITERS = 6,
  parameter int CW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  fpdiv_ctrl_if.slave ctl
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ITER_A = 3'd1,
    ITER_B = 3'd2,
    REM    = 3'd3,
    RES    = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q,  iter_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // abort wins over every transition once a division is under way
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    if (state_q != IDLE && ctl.abort) begin
      state_d = IDLE;
      iter_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          iter_d = '0;
          if (ctl.start && !ctl.abort) begin
            state_d = ITER_A;
            iter_d  = ONE;
          end
        end
        ITER_A: state_d = ITER_B;
        ITER_B: begin
          if (iter_q >= LAST_ITER) begin
            state_d = REM;
          end else begin
            state_d = ITER_A;
            iter_d  = iter_q + ONE;
          end
        end
`ifdef FPDIV_CTRL_RESULT_REG_EN
        REM: state_d = RES;
        RES: begin
          state_d = DONE;
          iter_d  = '0;
        end
`else
        REM: begin
          state_d = DONE;
          iter_d  = '0;
        end
`endif
        DONE: begin
          state_d = IDLE;
          iter_d  = '0;
        end
        default: begin
          state_d = IDLE;
          iter_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctl.busy     = 1'b0;
    ctl.done     = 1'b0;
    ctl.sel_mux4 = 2'b00;
    ctl.sel_mux3 = 2'b00;
    ctl.en_a     = 1'b0;
    ctl.en_b     = 1'b0;
    ctl.en_rem   = 1'b0;
    ctl.en_q     = 1'b0;
    ctl.iter     = iter_q;
    case (state_q)
      ITER_A: begin
        ctl.busy = 1'b1;
        ctl.en_a = 1'b1;
        if (iter_q != ONE) begin
          ctl.sel_mux4 = 2'b10;
          ctl.sel_mux3 = 2'b01;
        end
      end
      ITER_B: begin
        ctl.busy = 1'b1;
        ctl.en_b = 1'b1;
        if (iter_q == ONE) begin
          ctl.sel_mux4 = 2'b01;
        end else begin
          ctl.sel_mux4 = 2'b11;
          ctl.sel_mux3 = 2'b01;
        end
      end
      REM: begin
        ctl.busy     = 1'b1;
        ctl.en_rem   = 1'b1;
        ctl.sel_mux4 = 2'b10;
        ctl.sel_mux3 = 2'b10;
      end
`ifdef FPDIV_CTRL_RESULT_REG_EN
      RES: begin
        ctl.busy     = 1'b1;
        ctl.en_q     = 1'b1;
        ctl.sel_mux4 = 2'b10;
        ctl.sel_mux3 = 2'b10;
      end
`endif
      DONE: begin
        ctl.done = 1'b1;
        ctl.iter = '0;
      end
      default: ctl.iter = '0;
    endcase
  end

  // datapath load enables are mutually exclusive and only live while busy
  a_en_onehot_busy: assert property (@(posedge clk) disable iff (!reset)
    ctl.busy |-> $onehot({ctl.en_a, ctl.en_b, ctl.en_rem, ctl.en_q}));
  a_en_quiet_idle: assert property (@(posedge clk) disable iff (!reset)
    !ctl.busy |-> ({ctl.en_a, ctl.en_b, ctl.en_rem, ctl.en_q} == 4'b0000));
  a_iter_bound: assert property (@(posedge clk) disable iff (!reset)
    iter_q <= LAST_ITER);

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed bench for fpdiv_ctrl: ITERS=6 and ITERS=1 instances, traces
// compared cycle by cycle against hand-derived control vectors.
module tb_fpdiv_ctrl;

`ifdef FPDIV_CTRL_RESULT_REG_EN
  localparam int RES_EXTRA = 1;
`else
  localparam int RES_EXTRA = 0;
`endif
  localparam int LAST6 = 2 * 6 + 2 + RES_EXTRA;
  localparam int LAST1 = 2 * 1 + 2 + RES_EXTRA;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fpdiv_ctrl_if #(.CW(4)) if6 ();
  fpdiv_ctrl_if #(.CW(4)) if1 ();

  fpdiv_ctrl #(.ITERS(6), .CW(4)) dut6 (.clk(clk), .reset(reset), .ctl(if6.slave));
  fpdiv_ctrl #(.ITERS(1), .CW(4)) dut1 (.clk(clk), .reset(reset), .ctl(if1.slave));

  // {busy, done, sel_mux4, sel_mux3, en_a, en_b, en_rem, en_q, iter}
  logic [13:0] obs6, obs1;
  assign obs6 = {if6.busy, if6.done, if6.sel_mux4, if6.sel_mux3,
                 if6.en_a, if6.en_b, if6.en_rem, if6.en_q, if6.iter};
  assign obs1 = {if1.busy, if1.done, if1.sel_mux4, if1.sel_mux3,
                 if1.en_a, if1.en_b, if1.en_rem, if1.en_q, if1.iter};

  // Expected control vector for cycle c of a division whose start was sampled at edge 0.
  function automatic logic [13:0] exp_vec(input int iters, input int c);
    int k;
    logic [13:0] v;
    v = '0;
    if (c >= 1 && c <= 2 * iters) begin
      k = (c + 1) / 2;
      if (c % 2 == 1)
        v = {2'b10, (k == 1) ? 2'b00 : 2'b10, (k == 1) ? 2'b00 : 2'b01, 4'b1000, 4'(k)};
      else
        v = {2'b10, (k == 1) ? 2'b01 : 2'b11, (k == 1) ? 2'b00 : 2'b01, 4'b0100, 4'(k)};
    end else if (c == 2 * iters + 1) begin
      v = {2'b10, 2'b10, 2'b10, 4'b0010, 4'(iters)};
    end else if (RES_EXTRA == 1 && c == 2 * iters + 2) begin
      v = {2'b10, 2'b10, 2'b10, 4'b0001, 4'(iters)};
    end else if (c == 2 * iters + 2 + RES_EXTRA) begin
      v = {2'b01, 4'b0000, 4'b0000, 4'b0000};
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #12;
    checks++;
    if (obs6 !== 14'h0) begin
      failures++;
      $display("FAIL reset_dut6 got=%h want=%h", obs6, 14'h0);
    end
    checks++;
    if (obs1 !== 14'h0) begin
      failures++;
      $display("FAIL reset_dut1 got=%h want=%h", obs1, 14'h0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_trace6();
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    for (int c = 1; c <= LAST6 + 1; c++) begin
      checks++;
      if (obs6 !== exp_vec(6, c)) begin
        failures++;
        $display("FAIL trace6 cycle=%0d got=%h want=%h", c, obs6, exp_vec(6, c));
      end
      tick();
    end
  endtask

  task automatic test_iters1();
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int c = 1; c <= LAST1 + 1; c++) begin
      checks++;
      if (obs1 !== exp_vec(1, c)) begin
        failures++;
        $display("FAIL trace1 cycle=%0d got=%h want=%h", c, obs1, exp_vec(1, c));
      end
      tick();
    end
  endtask

  task automatic test_abort();
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (obs6 !== exp_vec(6, c)) begin
        failures++;
        $display("FAIL abort_pre cycle=%0d got=%h want=%h", c, obs6, exp_vec(6, c));
      end
      if (c == 6) if6.abort = 1'b1;
      tick();
    end
    if6.abort = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs6 !== 14'h0) begin
        failures++;
        $display("FAIL abort_idle cycle=%0d got=%h want=%h", c, obs6, 14'h0);
      end
      tick();
    end
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    for (int c = 1; c <= LAST6 + 1; c++) begin
      checks++;
      if (obs6 !== exp_vec(6, c)) begin
        failures++;
        $display("FAIL abort_restart cycle=%0d got=%h want=%h", c, obs6, exp_vec(6, c));
      end
      tick();
    end
  endtask

  task automatic test_abort_start_idle();
    if6.start = 1'b1;
    if6.abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs6 !== 14'h0) begin
        failures++;
        $display("FAIL abort_start_idle cycle=%0d got=%h want=%h", c, obs6, 14'h0);
      end
    end
    if6.start = 1'b0;
    if6.abort = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    if6.start = 1'b1;
    tick();
    for (int c = 1; c <= 2 * (LAST6 + 1); c++) begin
      e = (c <= LAST6 + 1) ? exp_vec(6, c) : exp_vec(6, c - LAST6 - 1);
      checks++;
      if (obs6 !== e) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got=%h want=%h", c, obs6, e);
      end
      if (c == LAST6 + 2) if6.start = 1'b0;
      tick();
    end
  endtask

  task automatic test_async_reset();
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    checks++;
    if (obs6 !== exp_vec(6, 6)) begin
      failures++;
      $display("FAIL async_pre got=%h want=%h", obs6, exp_vec(6, 6));
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (obs6 !== 14'h0) begin
      failures++;
      $display("FAIL async_immediate got=%h want=%h", obs6, 14'h0);
    end
    #2 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs6 !== 14'h0) begin
        failures++;
        $display("FAIL async_post_idle cycle=%0d got=%h want=%h", c, obs6, 14'h0);
      end
    end
    if6.start = 1'b1;
    tick();
    if6.start = 1'b0;
    for (int c = 1; c <= LAST6 + 1; c++) begin
      checks++;
      if (obs6 !== exp_vec(6, c)) begin
        failures++;
        $display("FAIL async_restart cycle=%0d got=%h want=%h", c, obs6, exp_vec(6, c));
      end
      tick();
    end
  endtask

  initial begin
    if6.start = 1'b0;
    if6.abort = 1'b0;
    if1.start = 1'b0;
    if1.abort = 1'b0;
    test_reset();
    test_trace6();
    test_iters1();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
- Control FSM for the Goldschmidt fpdiv datapath.
- Generates the mux selects and register enables that sequence the datapath: seed multiply, ITERS refinement iterations, then remainder capture.
- A start/busy/done handshake replaces hand-driven control.
- Sits beside fpdiv; its outputs connect one-to-one to the fpdiv control inputs.

Parameters:
- ITERS, 6, total iterations including the seed (IA) iteration; legal range 1..15.
- CW, 4, width of the iteration counter; must satisfy 2^CW > ITERS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin a division; sampled only in IDLE.
- abort  in  1  synchronous abandon; returns FSM to IDLE.
- busy  out  1  high while a division is in progress (ITER_A, ITER_B, REM, RES states).
- done  out  1  one-cycle pulse when the quotient and remainder registers are valid.
- sel_mux4  out  2  multiplier operand select: 00 = numerator × IA, 01 = denominator × IA, 10 = reg A × reg C, 11 = reg B × reg C.
- sel_mux3  out  2  multiplier second operand: 00 = IA seed, 01 = reg C (2 − B), 10 = remainder path.
- en_a  out  1  load reg A (numerator chain).
- en_b  out  1  load reg B (denominator chain) and reg C.
- en_rem  out  1  load remainder register.
- en_q  out  1  load quotient output register; only driven under FPDIV_CTRL_RESULT_REG_EN, constant 0 otherwise.
- iter  out  CW  current iteration number; 0 in IDLE, 1..ITERS during iterations.

Behaviour:
- Moore FSM; every output is a decode of the registered state plus iter.
- States: IDLE, ITER_A, ITER_B, REM, RES (macro only), DONE.
- Reset (reset = 0, asynchronous):
  - state = IDLE, iter = 0.
  - All outputs 0: sel_mux4 = 00, sel_mux3 = 00, en_* = 0, busy = 0, done = 0.
- IDLE: all outputs 0. If start = 1 and abort = 0 → ITER_A with iter = 1.
- ITER_A:
  - en_a = 1, en_b = 0, en_rem = 0.
  - iter = 1: sel_mux4 = 00, sel_mux3 = 00.
  - iter > 1: sel_mux4 = 10, sel_mux3 = 01.
  - Next state: ITER_B.
- ITER_B:
  - en_b = 1, en_a = 0.
  - iter = 1: sel_mux4 = 01, sel_mux3 = 00.
  - iter > 1: sel_mux4 = 11, sel_mux3 = 01.
  - If iter == ITERS → REM; else → ITER_A with iter + 1.
- REM:
  - sel_mux4 = 10, sel_mux3 = 10, en_rem = 1, en_a = en_b = 0.
  - Next state: RES if the macro is defined, else DONE.
- DONE:
  - done = 1, busy = 0, all enables 0, iter = 0.
  - Next state: IDLE unconditionally. start in DONE is ignored.
- Latency, start sampled at edge 0:
  - ITER_A entered after edge 0.
  - REM occupies cycle 2·ITERS+1.
  - done asserted in cycle 2·ITERS+2 (cycle 14 for ITERS = 6).
  - Back-to-back issue: next start is accepted no earlier than the cycle after done.
- start while busy: ignored; no queuing.
- abort = 1 in any non-IDLE state:
  - Next state is IDLE, iter = 0, no done pulse.
  - abort has priority over start and over normal transitions.
- abort and start together in IDLE: stays in IDLE.
- Exactly one of en_a / en_b / en_rem / en_q is high in any busy cycle; none are high in IDLE or DONE.
- iter saturates: the counter never increments past ITERS.
- Reset asserted mid-division: immediate return to IDLE, all outputs 0, no done.

Optional Feature:
- Macro: FPDIV_CTRL_RESULT_REG_EN.
- Defined:
  - RES state is inserted after REM: en_q = 1, sel_mux4 = 10, sel_mux3 = 10, busy = 1.
  - RES → DONE; done is asserted at cycle 2·ITERS+3.
- Undefined:
  - No RES state; en_q tied to 0.
  - done is asserted at cycle 2·ITERS+2.

Test Plan:
- Reset, then ITERS = 6 and a start pulse → control trace:
  - (00,00,a), (01,00,b), then five × [(10,01,a), (11,01,b)].
  - Then REM (10,10,rem).
  - done = 1 at cycle 14; busy high for cycles 1–13.
- abort asserted in ITER_B with iter = 3 → next cycle IDLE, all outputs 0, no done pulse; a subsequent start restarts at iter = 1.
- start held high continuously → divisions run back-to-back with one IDLE cycle between done and the next ITER_A; start is ignored during busy.
- ITERS = 1 → sequence ITER_A(00,00), ITER_B(01,00), REM, then done at cycle 4.
- reset driven low asynchronously mid-iteration (between clock edges) → outputs go to 0 immediately; after release the FSM stays in IDLE until start.
- FPDIV_CTRL_RESULT_REG_EN defined → en_q = 1 at cycle 14, done at cycle 15; without the macro, en_q never rises.
